// File: rtl/dot_product_sched.sv
// rtl/dot_product_sched.sv - round-robin job scheduler in front of one streaming dot-product engine
// Optional: DOT_PRODUCT_SCHED_RUN_WAIT_EN makes DRAIN wait on eng_run (with timeout) instead of a fixed count.
module dot_product_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 18,
  parameter int N_REQ      = 2,
  parameter int VEC_LEN    = 13,
  parameter int CLR_CYCLES = 5,
  parameter int ENG_LAT    = 2
) (
  input  logic                          clk,
  input  logic                          resetn_tb,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          eng_clr_n,
  output logic [DATA_WIDTH-1:0]         eng_din,
  input  logic [ACC_WIDTH-1:0]          eng_dout,
  input  logic                          eng_run,
  output logic                          rsp_valid,
  output logic [$clog2(N_REQ)-1:0]      rsp_id,
  output logic [ACC_WIDTH-1:0]          rsp_data,
  output logic                          rsp_err,
  output logic                          busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int MAX_A = (VEC_LEN > CLR_CYCLES) ? VEC_LEN : CLR_CYCLES;
  localparam int MAX_B = (MAX_A > ENG_LAT) ? MAX_A : ENG_LAT;
`ifdef DOT_PRODUCT_SCHED_RUN_WAIT_EN
  localparam int RUN_TIMEOUT = 4 * ENG_LAT + 4;
  localparam int CNT_MAX     = (MAX_B > RUN_TIMEOUT) ? MAX_B : RUN_TIMEOUT;
`else
  localparam int CNT_MAX     = MAX_B;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  clr_n_q, clr_n_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic [ACC_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  pick_found;
  logic [ID_W-1:0]       pick_id;
  logic [ID_W:0]         pick_idx;
  logic                  cur_valid;
  logic [DATA_WIDTH-1:0] cur_data;

`ifndef DOT_PRODUCT_SCHED_RUN_WAIT_EN
  logic unused_eng_run;
  assign unused_eng_run = eng_run;
`endif

  // Rotating priority search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pick_idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (pick_idx >= (ID_W+1)'(N_REQ)) begin
        pick_idx = pick_idx - (ID_W+1)'(N_REQ);
      end
      if (!pick_found && req_valid[pick_idx[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = pick_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    cur_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q == ID_W'(i)) begin
        cur_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign cur_valid = req_valid[gnt_q];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    clr_n_d    = 1'b1;
    din_d      = '0;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = '0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d   = pick_id;
          ptr_d   = (pick_id == ID_W'(N_REQ-1)) ? '0 : pick_id + ID_W'(1);
          cnt_d   = '0;
          clr_n_d = 1'b0;
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        // Clear is registered, so it was already driven low on the grant edge.
        if (cnt_q == CNT_W'(CLR_CYCLES-1)) begin
          cnt_d   = '0;
          state_d = STREAM;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          clr_n_d = 1'b0;
        end
      end

      STREAM: begin
        req_ready[gnt_q] = 1'b1;
        if (cur_valid) begin
          din_d = cur_data;
          if (cnt_q == CNT_W'(VEC_LEN-1)) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (cnt_q != '0) begin
          clr_n_d    = 1'b0;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          rsp_id_d   = gnt_q;
          state_d    = RESP;
        end
      end

      DRAIN: begin
`ifdef DOT_PRODUCT_SCHED_RUN_WAIT_EN
        if (eng_run) begin
          rsp_data_d = eng_dout;
          rsp_err_d  = 1'b0;
          rsp_id_d   = gnt_q;
          state_d    = RESP;
        end else if (cnt_q == CNT_W'(RUN_TIMEOUT-1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          rsp_id_d   = gnt_q;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        // cnt_q == 0 is the cycle the last sample sits on eng_din.
        if (cnt_q == CNT_W'(ENG_LAT)) begin
          rsp_data_d = eng_dout;
          rsp_err_d  = 1'b0;
          rsp_id_d   = gnt_q;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn_tb) begin
    if (!resetn_tb) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      cnt_q      <= '0;
      clr_n_q    <= 1'b0;
      din_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      clr_n_q    <= clr_n_d;
      din_q      <= din_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign eng_clr_n = clr_n_q;
  assign eng_din   = din_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dot_product_sched.sv
// tb/tb_dot_product_sched.sv - directed bench for dot_product_sched with a running-sum engine stub
// Build with DOT_PRODUCT_SCHED_RUN_WAIT_EN to exercise the eng_run timeout path.
module tb_dot_product_sched;

  localparam int DW = 8;
  localparam int AW = 18;

  logic          clk;
  logic          resetn_tb;
  logic [1:0]    req_valid;
  logic [2*DW-1:0] req_data;
  logic [1:0]    req_ready;
  logic          eng_clr_n;
  logic [DW-1:0] eng_din;
  logic [AW-1:0] eng_dout;
  logic          eng_run;
  logic          rsp_valid;
  logic [0:0]    rsp_id;
  logic [AW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;

  dot_product_sched dut (
    .clk       (clk),
    .resetn_tb (resetn_tb),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .eng_clr_n (eng_clr_n),
    .eng_din   (eng_din),
    .eng_dout  (eng_dout),
    .eng_run   (eng_run),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine stub: running sum plus one output register gives a 2-cycle latency.
  logic [AW-1:0] eng_acc;
  always @(posedge clk) begin
    if (!eng_clr_n) eng_acc <= '0;
    else            eng_acc <= eng_acc + AW'(eng_din);
    eng_dout <= eng_acc;
  end
  assign eng_run = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int idx[2];
  int acc_cnt[2];
  bit en[2];
  int drop[2];
  bit pend[2];
  int first_acc;
  int clr_run, last_clr_run;
  int ready1_early;
  int r_id[$], r_data[$], r_err[$], r_cyc[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit v[2];
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (pend[i]) begin
        idx[i] = (idx[i] == 12) ? 0 : idx[i] + 1;
        acc_cnt[i]++;
      end
    end
    if (rsp_valid) begin
      r_id.push_back(int'(rsp_id));
      r_data.push_back(int'(rsp_data));
      r_err.push_back(int'(rsp_err));
      r_cyc.push_back(cyc);
    end
    if (!eng_clr_n) clr_run++;
    else begin
      if (clr_run != 0) last_clr_run = clr_run;
      clr_run = 0;
    end
    if (req_ready[1] && r_id.size() == 0) ready1_early++;
    for (int i = 0; i < 2; i++) v[i] = en[i] && (drop[i] == 0 || acc_cnt[i] < drop[i]);
    req_valid = {v[1], v[0]};
    req_data  = {DW'(2), DW'(idx[0] + 1)};
    for (int i = 0; i < 2; i++) pend[i] = v[i] && req_ready[i];
    if ((pend[0] || pend[1]) && first_acc < 0) first_acc = cyc;
  endtask

  task automatic clear_bench();
    for (int i = 0; i < 2; i++) begin
      idx[i] = 0; acc_cnt[i] = 0; pend[i] = 1'b0;
    end
    first_acc = -1;
    ready1_early = 0;
    r_id.delete(); r_data.delete(); r_err.delete(); r_cyc.delete();
  endtask

  task automatic do_reset();
    resetn_tb = 1'b0;
    clear_bench();
    repeat (3) tick();
    clear_bench();
    resetn_tb = 1'b1;
  endtask

  task automatic wait_rsp(input int n, input string tag, output bit ok);
    for (int i = 0; i < 400 && r_id.size() < n; i++) tick();
    ok = (r_id.size() >= n);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d responses expected %0d", tag, r_id.size(), n);
    end
  endtask

  initial begin
    bit ok;
    int n_before;
    resetn_tb = 1'b0;
    req_valid = '0;
    req_data  = '0;
    en[0] = 0; en[1] = 0; drop[0] = 0; drop[1] = 0;
    clr_run = 0; last_clr_run = 0;
    clear_bench();

    // Reset values
    tick(); tick();
    check_eq("rst_clr_n", eng_clr_n, 0);
    check_eq("rst_din", eng_din, 0);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_id", rsp_id, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_busy", busy, 0);
    resetn_tb = 1'b1;
    tick();
    check_eq("clr_n_after_rst", eng_clr_n, 1);

`ifndef DOT_PRODUCT_SCHED_RUN_WAIT_EN
    // Single job
    en[0] = 1; drop[0] = 13;
    wait_rsp(1, "single", ok);
    if (ok) begin
      check_eq("single_id", r_id[0], 0);
      check_eq("single_data", r_data[0], 91);
      check_eq("single_err", r_err[0], 0);
      check_eq("single_latency", r_cyc[0] - first_acc, 16);
      check_eq("single_clr_len", last_clr_run, 5);
    end
    tick();
    check_eq("single_idle", busy, 0);

    // Contention
    en[0] = 1; en[1] = 1; drop[0] = 13; drop[1] = 13;
    do_reset();
    wait_rsp(2, "contend", ok);
    if (ok) begin
      check_eq("contend_id0", r_id[0], 0);
      check_eq("contend_data0", r_data[0], 91);
      check_eq("contend_id1", r_id[1], 1);
      check_eq("contend_data1", r_data[1], 26);
      check_eq("contend_ready1_early", ready1_early, 0);
    end

    // Fairness
    drop[0] = 0; drop[1] = 0;
    do_reset();
    wait_rsp(4, "fair", ok);
    if (ok) begin
      for (int j = 0; j < 4; j++) begin
        check_eq($sformatf("fair_id%0d", j), r_id[j], j % 2);
        check_eq($sformatf("fair_data%0d", j), r_data[j], (j % 2 == 0) ? 91 : 26);
      end
    end

    // Abort after the 6th sample of requester 1
    en[0] = 0; en[1] = 1; drop[1] = 6;
    do_reset();
    wait_rsp(1, "abort", ok);
    if (ok) begin
      check_eq("abort_id", r_id[0], 1);
      check_eq("abort_err", r_err[0], 1);
      check_eq("abort_data", r_data[0], 0);
      check_eq("abort_accepts", acc_cnt[1], 6);
    end
    tick(); tick();
    check_eq("abort_clr_pulse", last_clr_run, 1);
    check_eq("abort_idle", busy, 0);

    // Reset mid-STREAM after 7 samples
    en[0] = 1; en[1] = 0; drop[0] = 13; drop[1] = 0;
    do_reset();
    for (int i = 0; i < 200 && acc_cnt[0] < 7; i++) tick();
    check_eq("midrst_accepts", acc_cnt[0], 7);
    resetn_tb = 1'b0;
    #1;
    check_eq("midrst_ready", req_ready, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_clr_n", eng_clr_n, 0);
    check_eq("midrst_din", eng_din, 0);
    check_eq("midrst_rsp_valid", rsp_valid, 0);
    check_eq("midrst_rsp_data", rsp_data, 0);
    n_before = r_id.size();
    do_reset();
    check_eq("midrst_no_rsp", n_before, 0);
    wait_rsp(1, "midrst", ok);
    if (ok) begin
      check_eq("midrst_next_id", r_id[0], 0);
      check_eq("midrst_next_data", r_data[0], 91);
      check_eq("midrst_next_err", r_err[0], 0);
    end
`else
    // eng_run never rises: timeout 12 cycles after DRAIN entry
    en[0] = 1; drop[0] = 13;
    wait_rsp(1, "runwait", ok);
    if (ok) begin
      check_eq("runwait_id", r_id[0], 0);
      check_eq("runwait_err", r_err[0], 1);
      check_eq("runwait_data", r_data[0], 0);
      check_eq("runwait_latency", r_cyc[0] - first_acc, 25);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_product_sched.md
Name: dot_product_sched

Overview:
- Round-robin scheduler sharing one streaming dot-product engine between N_REQ vector requesters.
- Per job: grant a requester, pulse the engine's synchronous clear, then stream exactly VEC_LEN contiguous samples into the engine.
- After the engine latency, capture its result and return it tagged with the requester id.
- Sits between the sample sources and the engine instance; the engine has no input valid, so the scheduler owns its clear and data timing.

Parameters:
- DATA_WIDTH, 8, sample width.
- ACC_WIDTH, 18, engine result width.
- N_REQ, 2, number of requesters (2..8).
- VEC_LEN, 13, samples per job.
- CLR_CYCLES, 5, cycles eng_clr_n is held low before streaming.
- ENG_LAT, 2, cycles from the last sample on eng_din to a valid eng_dout.

Ports:
- clk  in  1  clock.
- resetn_tb  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester sample valid.
- req_data  in  N_REQ*DATA_WIDTH  packed samples; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  N_REQ  per-requester sample accept.
- eng_clr_n  out  1  engine synchronous clear, active-low.
- eng_din  out  DATA_WIDTH  engine sample input.
- eng_dout  in  ACC_WIDTH  engine result.
- eng_run  in  1  engine result-valid flag.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  $clog2(N_REQ)  id of the served requester.
- rsp_data  out  ACC_WIDTH  captured result.
- rsp_err  out  1  job aborted; rsp_data is 0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (asynchronous): state IDLE, eng_clr_n 0, eng_din 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0, busy 0, round-robin pointer 0.
  - eng_clr_n goes to 1 on the first clk after reset deassertion.
- States: IDLE, CLEAR, STREAM, DRAIN, RESP.
- IDLE:
  - If any req_valid is high, grant the first set bit searching upward from the pointer, with wrap-around.
  - Latch the grant id g, set pointer to g+1 mod N_REQ, go to CLEAR.
  - After reset with both requesters valid, requester 0 is served first.
- CLEAR:
  - eng_clr_n = 0 for exactly CLR_CYCLES cycles, eng_din = 0, then go to STREAM.
- STREAM:
  - req_ready[g] = 1 combinationally; all other ready bits are 0.
  - An accepted sample (valid & ready) is registered to eng_din on the next edge.
  - The sample counter increments per accept. The VEC_LEN-th accept goes to DRAIN and deasserts ready in the same cycle as that accept.
  - If req_valid[g] is low in any STREAM cycle after the first accept: abort. Go to RESP with rsp_err = 1, rsp_data = 0, and drive eng_clr_n low for one cycle.
  - Before the first accept the scheduler waits indefinitely with no abort.
- DRAIN:
  - eng_din returns to 0 the cycle after the last sample.
  - Count ENG_LAT cycles from the cycle the last sample appears on eng_din, then capture eng_dout into rsp_data and go to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle, with rsp_id = g. Then go to IDLE.
  - rsp_data and rsp_id hold until the next RESP.
  - There is no backpressure on the response.
- Latency: first accept to rsp_valid = VEC_LEN + ENG_LAT + 1 cycles.
- Requests arriving while busy are not accepted; they are considered in IDLE, one cycle after RESP.
- Reset asserted mid-job: immediate return to reset values. No rsp_valid is issued and the pointer returns to 0.
- Counters are sized $clog2(max(VEC_LEN, CLR_CYCLES, ENG_LAT)+1) and never wrap.

Optional Feature:
- Macro: DOT_PRODUCT_SCHED_RUN_WAIT_EN.
- With it defined:
  - DRAIN waits for eng_run = 1 instead of the fixed ENG_LAT count, and captures eng_dout in that cycle.
  - If eng_run stays low for 4*ENG_LAT+4 cycles, the job completes with rsp_err = 1 and rsp_data = 0.
- Without it: eng_run is ignored and the fixed ENG_LAT count is used.

Test Plan:
- Single job: requester 0 streams 1..13 back-to-back; bench engine stub is a running sum with ENG_LAT = 2. Required: eng_clr_n low for 5 cycles, then rsp_valid with rsp_id = 0, rsp_data = 91, rsp_err = 0, exactly 16 cycles after the first accept.
- Contention: both requesters valid from reset, requester 0 sending 1..13 and requester 1 sending all 2s. Required: rsp_id 0 with 91, then rsp_id 1 with 26. req_ready[1] stays 0 during job 0.
- Fairness: both requesters continuously valid for 4 jobs. Required: rsp_id sequence 0, 1, 0, 1.
- Abort: requester 1 drops req_valid after its 6th sample. Required: rsp_valid with rsp_err = 1, rsp_data = 0, rsp_id = 1; one-cycle eng_clr_n low pulse; scheduler returns to IDLE.
- Reset mid-STREAM: assert resetn_tb after 7 samples. Required: all outputs at reset values within the same cycle, no rsp_valid. The next job after release returns 91.
- With DOT_PRODUCT_SCHED_RUN_WAIT_EN, stub eng_run never rises. Required: rsp_err = 1 exactly 12 cycles after DRAIN entry.
